ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 120 ++++++++++++
 tb/tb_ram_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - single-port RAM arbiter between CPU and a debug read port (optional stall counter: RAM_ARB_STATS_EN)
module ram_arbiter #(
  parameter int ADDR_BITS = 12,
  parameter int MAX_WAIT  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req,
  input  logic [ADDR_BITS-3:0] cpu_addr,
  input  logic                 cpu_rw,
  input  logic [3:0]           cpu_sel,
  input  logic [31:0]          cpu_wdata,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_stall,
  input  logic                 dbg_req,
  input  logic [ADDR_BITS-3:0] dbg_addr,
  output logic                 dbg_ack,
  output logic [31:0]          dbg_rdata,
  output logic [ADDR_BITS-3:0] ram_addr,
  output logic [31:0]          ram_data_in,
  output logic [3:0]           ram_sel,
  output logic                 ram_rw,
  input  logic [31:0]          ram_data_out,
  output logic [31:0]          stall_cycles
);

  localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

  typedef enum logic {ST_ARB = 1'b0, ST_ACK = 1'b1} state_t;

  state_t      r_state;
  logic [3:0]  r_wait_cnt;
  logic        r_dbg_ack;
  logic [31:0] r_dbg_rdata;

  logic w_in_arb;
  logic w_dbg_grant;
  logic w_cpu_grant;

  // A reset cycle arbitrates as if the FSM were already back in ARB
  assign w_in_arb    = rst || (r_state == ST_ARB);
  assign w_dbg_grant = w_in_arb && dbg_req && (!cpu_req || (r_wait_cnt >= LP_MAX_WAIT));
  assign w_cpu_grant = cpu_req && !w_dbg_grant;

  assign cpu_stall   = cpu_req && !w_cpu_grant;
  assign cpu_rdata   = ram_data_out;
  assign dbg_ack     = r_dbg_ack;
  assign dbg_rdata   = r_dbg_rdata;
  assign ram_data_in = cpu_wdata;

  // Steer the single RAM port to whichever requester owns this cycle
  always_comb begin
    ram_addr = cpu_addr;
    ram_rw   = 1'b0;
    ram_sel  = 4'b0000;
    if (w_dbg_grant) begin
      ram_addr = dbg_addr;
      ram_sel  = 4'b1111;
    end else if (w_cpu_grant) begin
      ram_rw  = cpu_rw && !rst;
      ram_sel = cpu_sel;
    end
  end

  // Two-state FSM: capture debug data at the grant edge, acknowledge in ACK
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_ARB;
      r_dbg_ack   <= 1'b0;
      r_dbg_rdata <= 32'h0;
    end else begin
      case (r_state)
        ST_ARB: begin
          if (w_dbg_grant) begin
            r_state     <= ST_ACK;
            r_dbg_ack   <= 1'b1;
            r_dbg_rdata <= ram_data_out;
          end else begin
            r_dbg_ack <= 1'b0;
          end
        end
        ST_ACK: begin
          r_state   <= ST_ARB;
          r_dbg_ack <= 1'b0;
        end
        default: begin
          r_state   <= ST_ARB;
          r_dbg_ack <= 1'b0;
        end
      endcase
    end
  end

  // Starvation counter for a denied debug request, saturating at MAX_WAIT
  always_ff @(posedge clk) begin
    if (rst || !dbg_req || w_dbg_grant) begin
      r_wait_cnt <= 4'd0;
    end else if (r_wait_cnt < LP_MAX_WAIT) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

`ifdef RAM_ARB_STATS_EN
  logic [31:0] r_stall_cycles;

  // Free-running count of stalled CPU cycles, wraps naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= 32'h0;
    end else if (cpu_stall) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`else
  assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - table-driven scoreboard bench for ram_arbiter
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [9:0]  cpu_addr;
  logic        cpu_rw;
  logic [3:0]  cpu_sel;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dbg_req;
  logic [9:0]  dbg_addr;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic [9:0]  ram_addr;
  logic [31:0] ram_data_in;
  logic [3:0]  ram_sel;
  logic        ram_rw;
  logic [31:0] ram_data_out;
  logic [31:0] stall_cycles;

  logic [31:0] mem [0:1023];
  logic        mem_load;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_BITS(12), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw), .cpu_sel(cpu_sel),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_sel(ram_sel), .ram_rw(ram_rw),
    .ram_data_out(ram_data_out), .stall_cycles(stall_cycles)
  );

  // RAM model: asynchronous read, byte-enabled write on the clock edge
  assign ram_data_out = mem[ram_addr];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[10'h010] <= 32'hDEADBEEF;
      mem[10'h030] <= 32'hAAAA5555;
    end else if (ram_rw === 1'b1) begin
      for (int b = 0; b < 4; b++)
        if (ram_sel[b]) mem[ram_addr][b*8 +: 8] <= ram_data_in[b*8 +: 8];
    end
  end

  typedef struct packed {
    logic        rst;
    logic        creq;
    logic [9:0]  caddr;
    logic        crw;
    logic [3:0]  csel;
    logic [31:0] cwd;
    logic        dreq;
    logic [9:0]  daddr;
    logic        e_stall;
    logic [9:0]  e_addr;
    logic        e_rw;
    logic [3:0]  e_sel;
    logic        e_ack;
    logic [31:0] e_rdata;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t        tbl[$];
  vec_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] cnt_model = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic creq, input logic [9:0] caddr, input logic crw,
                     input logic [3:0] csel, input logic [31:0] cwd, input logic dreq,
                     input logic [9:0] daddr, input logic e_stall, input logic [9:0] e_addr,
                     input logic e_rw, input logic [3:0] e_sel, input logic e_ack,
                     input logic [31:0] e_rdata);
    vec_t v;
    v = '{r, creq, caddr, crw, csel, cwd, dreq, daddr, e_stall, e_addr, e_rw, e_sel,
          e_ack, e_rdata, 32'h0};
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    rst       = v.rst;
    cpu_req   = v.creq;
    cpu_addr  = v.caddr;
    cpu_rw    = v.crw;
    cpu_sel   = v.csel;
    cpu_wdata = v.cwd;
    dbg_req   = v.dreq;
    dbg_addr  = v.daddr;
  endtask

  initial begin
    vec_t v;
    vec_t e;
    bit   seen;

    //   rst req caddr  rw sel  wdata         dreq daddr  | stall addr  rw sel  ack rdata
    add(1, 0, 10'h000, 0, 4'hF, 32'h0,        0, 10'h000,  0, 10'h000, 0, 4'h0, 0, 32'h0);
    add(0, 1, 10'h001, 0, 4'hF, 32'h0,        0, 10'h000,  0, 10'h001, 0, 4'hF, 0, 32'h0);
    add(0, 1, 10'h002, 1, 4'h3, 32'h11112222, 0, 10'h000,  0, 10'h002, 1, 4'h3, 0, 32'h0);
    add(0, 1, 10'h3FF, 0, 4'hF, 32'h0,        0, 10'h000,  0, 10'h3FF, 0, 4'hF, 0, 32'h0);
    add(0, 0, 10'h004, 0, 4'hF, 32'h0,        1, 10'h010,  0, 10'h010, 0, 4'hF, 0, 32'h0);
    add(0, 0, 10'h005, 0, 4'hF, 32'h0,        1, 10'h010,  0, 10'h005, 0, 4'h0, 1, 32'hDEADBEEF);
    add(0, 0, 10'h006, 0, 4'hF, 32'h0,        0, 10'h010,  0, 10'h006, 0, 4'h0, 0, 32'hDEADBEEF);
    add(0, 1, 10'h040, 0, 4'hF, 32'h0,        1, 10'h030,  0, 10'h040, 0, 4'hF, 0, 32'hDEADBEEF);
    add(0, 1, 10'h040, 0, 4'hF, 32'h0,        1, 10'h030,  0, 10'h040, 0, 4'hF, 0, 32'hDEADBEEF);
    add(0, 1, 10'h040, 0, 4'hF, 32'h0,        1, 10'h030,  0, 10'h040, 0, 4'hF, 0, 32'hDEADBEEF);
    add(0, 1, 10'h040, 0, 4'hF, 32'h0,        1, 10'h030,  0, 10'h040, 0, 4'hF, 0, 32'hDEADBEEF);
    add(0, 1, 10'h040, 0, 4'hF, 32'h0,        1, 10'h030,  1, 10'h030, 0, 4'hF, 0, 32'hDEADBEEF);
    add(0, 1, 10'h040, 0, 4'hF, 32'h0,        1, 10'h030,  0, 10'h040, 0, 4'hF, 1, 32'hAAAA5555);
    add(0, 1, 10'h040, 0, 4'hF, 32'h0,        0, 10'h030,  0, 10'h040, 0, 4'hF, 0, 32'hAAAA5555);
    add(0, 1, 10'h050, 0, 4'hF, 32'h0,        1, 10'h020,  0, 10'h050, 0, 4'hF, 0, 32'hAAAA5555);
    add(0, 1, 10'h050, 0, 4'hF, 32'h0,        1, 10'h020,  0, 10'h050, 0, 4'hF, 0, 32'hAAAA5555);
    add(0, 1, 10'h050, 0, 4'hF, 32'h0,        1, 10'h020,  0, 10'h050, 0, 4'hF, 0, 32'hAAAA5555);
    add(0, 1, 10'h020, 1, 4'hF, 32'h12345678, 1, 10'h020,  0, 10'h020, 1, 4'hF, 0, 32'hAAAA5555);
    add(0, 1, 10'h050, 0, 4'hF, 32'h0,        1, 10'h020,  1, 10'h020, 0, 4'hF, 0, 32'hAAAA5555);
    add(0, 1, 10'h050, 0, 4'hF, 32'h0,        1, 10'h020,  0, 10'h050, 0, 4'hF, 1, 32'h12345678);
    add(0, 1, 10'h050, 0, 4'hF, 32'h0,        0, 10'h020,  0, 10'h050, 0, 4'hF, 0, 32'h12345678);
    add(0, 0, 10'h000, 0, 4'hF, 32'h0,        1, 10'h010,  0, 10'h010, 0, 4'hF, 0, 32'h12345678);
    add(1, 1, 10'h060, 1, 4'hF, 32'hFFFFFFFF, 1, 10'h010,  0, 10'h060, 0, 4'hF, 1, 32'hDEADBEEF);
    add(0, 0, 10'h000, 0, 4'hF, 32'h0,        0, 10'h000,  0, 10'h000, 0, 4'h0, 0, 32'h0);
    add(0, 1, 10'h002, 1, 4'h4, 32'h00AB0000, 0, 10'h000,  0, 10'h002, 1, 4'h4, 0, 32'h0);

    v = '0;
    drive(v);
    rst      = 1'b1;
    mem_load = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mem_load = 1'b0;

    foreach (tbl[i]) begin
      v = tbl[i];
`ifdef RAM_ARB_STATS_EN
      v.e_cnt = cnt_model;
`else
      v.e_cnt = 32'h0;
`endif
      if (v.rst) cnt_model = 32'h0;
      else if (v.e_stall) cnt_model = cnt_model + 32'd1;
      drive(v);
      sb.push_back(v);
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("row%0d cpu_stall", i), {31'h0, cpu_stall}, {31'h0, e.e_stall});
      chk($sformatf("row%0d ram_addr", i), {22'h0, ram_addr}, {22'h0, e.e_addr});
      chk($sformatf("row%0d ram_rw", i), {31'h0, ram_rw}, {31'h0, e.e_rw});
      chk($sformatf("row%0d ram_sel", i), {28'h0, ram_sel}, {28'h0, e.e_sel});
      chk($sformatf("row%0d dbg_ack", i), {31'h0, dbg_ack}, {31'h0, e.e_ack});
      chk($sformatf("row%0d dbg_rdata", i), dbg_rdata, e.e_rdata);
      chk($sformatf("row%0d stall_cycles", i), stall_cycles, e.e_cnt);
      @(posedge clk);
      #1;
    end

    // Debug read of a byte-merged word: bytes 0-1 from one write, byte 2 from another
    v = '0;
    v.dreq    = 1'b1;
    v.daddr   = 10'h002;
    v.e_rdata = 32'h00AB2222;
    drive(v);
    sb.push_back(v);
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (dbg_ack === 1'b1) begin
        seen = 1'b1;
        e = sb.pop_front();
        chk("merged dbg_rdata", dbg_rdata, e.e_rdata);
        chk("ack latency", c, 0);
        dbg_req = 1'b0;
      end
    end
    if (!seen) chk("dbg_ack timeout", 32'h0, 32'h1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("ack single pulse", {31'h0, dbg_ack}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
